// File: rtl/icache_ctrl_if.sv
// rtl/icache_ctrl_if.sv - shared cache types and the IFU/refill bus of icache_ctrl
package mmm_pkg;
  localparam int XLEN          = 32;
  localparam int ICACHE_LINE_W = 128;
  localparam int ICACHE_OFFSET = 4;
  localparam int ICACHE_SETS   = 16;

  typedef struct packed {
    logic [ICACHE_LINE_W-1:0] line;
    logic [XLEN-1:0]          pc;
  } icache_out_t;
endpackage

interface icache_ctrl_if;
  import mmm_pkg::*;

  logic                     flush_i;
  logic                     invalidate_i;
  logic [XLEN-1:0]          addr_i;
  logic                     read_req_i;
  logic                     read_done_o;
  icache_out_t              cache_out_o;
  logic                     mem_req_valid_o;
  logic                     mem_req_ready_i;
  logic [XLEN-1:0]          mem_addr_o;
  logic                     mem_resp_valid_i;
  logic [ICACHE_LINE_W-1:0] mem_resp_data_i;

  modport slave (
    input  flush_i, invalidate_i, addr_i, read_req_i,
    input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    output read_done_o, cache_out_o, mem_req_valid_o, mem_addr_o
  );

  modport master (
    output flush_i, invalidate_i, addr_i, read_req_i,
    output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    input  read_done_o, cache_out_o, mem_req_valid_o, mem_addr_o
  );
endinterface

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache controller with single-line refill
module icache_ctrl
  import mmm_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  icache_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(ICACHE_SETS);
  localparam int TAG_W = XLEN - ICACHE_OFFSET - IDX_W;

  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT} state_t;
  state_t state_q, state_d;

  logic [ICACHE_SETS-1:0]   valid_q;
  logic [TAG_W-1:0]         tag_q  [ICACHE_SETS];
  logic [ICACHE_LINE_W-1:0] line_q [ICACHE_SETS];

  logic            done_q, done_d;
  icache_out_t     out_q, out_d;
  logic            mem_req_valid_q;
  logic [XLEN-1:0] mem_addr_q;
  logic            abort_q, abort_d;
  logic            inv_q, inv_d;
  logic            miss_start, fill_en, fill_valid;

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [XLEN-1:0]  req_pc;
  logic             hit, sample_req;
  logic             unused_offset;

  assign req_idx       = bus.addr_i[ICACHE_OFFSET+IDX_W-1:ICACHE_OFFSET];
  assign req_tag       = bus.addr_i[XLEN-1:ICACHE_OFFSET+IDX_W];
  assign req_pc        = {bus.addr_i[XLEN-1:ICACHE_OFFSET], {ICACHE_OFFSET{1'b0}}};
  assign unused_offset = ^bus.addr_i[ICACHE_OFFSET-1:0];
  assign fill_idx      = mem_addr_q[ICACHE_OFFSET+IDX_W-1:ICACHE_OFFSET];
  assign fill_tag      = mem_addr_q[XLEN-1:ICACHE_OFFSET+IDX_W];

  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign sample_req = (state_q == IDLE) && bus.read_req_i && !bus.flush_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (sample_req && !hit)   state_d = MEM_REQ;
      MEM_REQ:  if (bus.mem_req_ready_i)  state_d = MEM_WAIT;
      MEM_WAIT: if (bus.mem_resp_valid_i) state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Flush/invalidate during a refill are remembered so the fill still lands but is muted.
  always_comb begin
    done_d     = 1'b0;
    out_d      = out_q;
    miss_start = 1'b0;
    fill_en    = 1'b0;
    fill_valid = 1'b0;
    abort_d    = abort_q;
    inv_d      = inv_q;
    case (state_q)
      IDLE: begin
        if (sample_req) begin
          if (hit) begin
            done_d    = 1'b1;
            out_d.line = line_q[req_idx];
            out_d.pc   = req_pc;
          end else begin
            miss_start = 1'b1;
            abort_d    = 1'b0;
            inv_d      = 1'b0;
          end
        end
      end
      MEM_REQ, MEM_WAIT: begin
        abort_d = abort_q | bus.flush_i;
        inv_d   = inv_q | bus.invalidate_i;
        if ((state_q == MEM_WAIT) && bus.mem_resp_valid_i) begin
          fill_en    = 1'b1;
          fill_valid = !inv_d;
          done_d     = !abort_d;
          if (!abort_d) begin
            out_d.line = bus.mem_resp_data_i;
            out_d.pc   = mem_addr_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      done_q          <= 1'b0;
      out_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      abort_q         <= 1'b0;
      inv_q           <= 1'b0;
      valid_q         <= '0;
    end else begin
      done_q          <= done_d;
      out_q           <= out_d;
      mem_req_valid_q <= (state_d == MEM_REQ);
      abort_q         <= abort_d;
      inv_q           <= inv_d;
      if (miss_start) mem_addr_q <= req_pc;
      // A refill landing in the invalidate cycle overrides the bulk clear for its own set.
      if (bus.invalidate_i) valid_q <= '0;
      if (fill_en) valid_q[fill_idx] <= fill_valid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      line_q[fill_idx] <= bus.mem_resp_data_i;
    end
  end

  assign bus.read_done_o     = done_q;
  assign bus.cache_out_o     = out_q;
  assign bus.mem_req_valid_o = mem_req_valid_q;
  assign bus.mem_addr_o      = mem_addr_q;
endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction-cache controller that serves line reads from the instruction fetch unit and refills missed lines from a next-level memory port. It is the responder for the IFU's `read_req`/`read_done` handshake and returns a full `icache_out_t` (line plus line-aligned PC). It also handles pipeline flushes, which abort delivery, and whole-cache invalidation for `fence.i`.

## Interface
Parameters:
- `XLEN`, 32: address width, from `mmm_pkg`.
- `ICACHE_LINE_W`, 128: line width in bits (4 × 32-bit instructions).
- `ICACHE_OFFSET`, 4: byte-offset bits, log2(`ICACHE_LINE_W`/8).
- `ICACHE_SETS`, 16: number of lines; `IDX_W` = log2(`ICACHE_SETS`) = 4.
- Tag width is derived: `TAG_W` = `XLEN` − `ICACHE_OFFSET` − `IDX_W` (24).

Ports:
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: pipeline flush; abort delivery of the pending request.
- `invalidate_i` in 1: clear all valid bits (`fence.i`).
- `addr_i` in `XLEN`: fetch PC. Only meaningful while `read_req_i`=1.
- `read_req_i` in 1: line read request. The IFU holds it until `read_done_o`.
- `read_done_o` out 1: one-cycle pulse; `cache_out_o` is valid.
- `cache_out_o` out `icache_out_t`:
  - `.line` is the `ICACHE_LINE_W` data.
  - `.pc` is the requested address with `[ICACHE_OFFSET-1:0]` cleared.
- `mem_req_valid_o` out 1: refill request valid.
- `mem_req_ready_i` in 1: memory accepts the request.
- `mem_addr_o` out `XLEN`: line-aligned refill address.
- `mem_resp_valid_i` in 1: refill data valid. Exactly one response per accepted request, arriving at least 1 cycle after acceptance.
- `mem_resp_data_i` in `ICACHE_LINE_W`: refill line.

## Operation
- Storage:
  - `ICACHE_SETS` entries of {valid, tag, line}, held in flops.
  - Reads are combinational, indexed by `addr_i[ICACHE_OFFSET+IDX_W-1:ICACHE_OFFSET]`.
- FSM states:
  - IDLE: accepts requests.
  - MEM_REQ: `mem_req_valid_o`=1.
  - MEM_WAIT: waiting for the response.
- IDLE, request sampled when `read_req_i`=1 and `flush_i`=0:
  - Hit (valid and tag match): register `read_done_o`=1 and `cache_out_o`, then stay in IDLE.
  - Miss: latch the aligned address into `mem_addr_o`, clear `abort_q`, go to MEM_REQ.
- MEM_REQ: hold `mem_req_valid_o` and `mem_addr_o` stable. When `mem_req_ready_i`=1, go to MEM_WAIT. Valid is never withdrawn, including on flush.
- MEM_WAIT, on `mem_resp_valid_i`=1:
  - Write the line, tag and valid=1 into the indexed set.
  - If `abort_q`=0, register `read_done_o`=1 with `.line`=`mem_resp_data_i` and `.pc`=`mem_addr_o`.
  - Go to IDLE.
- Flush:
  - In IDLE, no request is sampled that cycle.
  - In MEM_REQ or MEM_WAIT, set `abort_q`. The refill completes and fills the array, but `read_done_o` is suppressed.
  - A `read_done_o` already registered for the flush cycle is not cancelled; the IFU discards it because its flush has priority.
- Invalidate:
  - Clears all valid bits at the next edge.
  - If `invalidate_i` is high during MEM_REQ or MEM_WAIT, set `inv_q`. The pending refill then writes data and tag but leaves valid=0; the line is still returned if not aborted.
  - A hit sampled in the same cycle as `invalidate_i` still completes.
- Simultaneous array write and request: not possible, because requests are sampled only in IDLE.
- Alignment: the offset bits of `addr_i` are ignored for lookup and zeroed in both `.pc` and `mem_addr_o`.

## Timing
- Reset values:
  - State IDLE.
  - All valid bits 0.
  - `read_done_o`=0, `cache_out_o`='0.
  - `mem_req_valid_o`=0, `mem_addr_o`='0.
  - `abort_q`=0, `inv_q`=0.
- Reset mid-refill returns to IDLE immediately. The memory side must be reset together with this block.
- Hit: request sampled at edge N, `read_done_o` high in cycle N+1.
  - During cycle N+1 the FSM is in IDLE, so a held or new request is sampled again.
  - Sustained hits therefore give 1 line per cycle.
- Miss:
  - Request sampled at edge N.
  - `mem_req_valid_o` high from cycle N+1 until the cycle `mem_req_ready_i`=1 (edge M).
  - Response at edge R (R > M).
  - `read_done_o` high in cycle R+1; the line hits from the next request on.
  - Minimum miss latency is 3 cycles (ready in N+1, response in N+2).
- `read_done_o` is always exactly one cycle wide and is never asserted outside these cases.

## Test plan
- Cold miss:
  - Stimulus: reset, then `read_req_i`=1 with `addr_i`=0x0000_1234; memory ready immediately and responds 2 cycles later with 0xDEAD...BEEF.
  - Response: `mem_addr_o`=0x0000_1230; one `read_done_o` pulse with `.pc`=0x0000_1230 and `.line`=0xDEAD...BEEF.
- Back-to-back hits:
  - Stimulus: after the cold miss, request 0x1230, 0x1238, 0x123C on consecutive cycles.
  - Response: three consecutive `read_done_o` pulses, all with the same line and `mem_req_valid_o` never asserted.
- Conflict miss:
  - Stimulus: request 0x0000_2234 (same index, different tag) after 0x1230 is cached.
  - Response: a refill is issued; afterwards 0x1230 misses again.
- Flush during refill:
  - Stimulus: `flush_i` during MEM_WAIT for 0x4000.
  - Response: no `read_done_o` for 0x4000. A later request to 0x4000 hits with 1-cycle latency.
- Invalidate:
  - Stimulus: pulse `invalidate_i` in IDLE, then request a previously cached line.
  - Response: refill issued.
  - Stimulus: `invalidate_i` during MEM_REQ.
  - Response: line returned, but the next access to it misses.
- Backpressure:
  - Stimulus: `mem_req_ready_i` held low for 5 cycles while `flush_i` pulses.
  - Response: `mem_req_valid_o` and `mem_addr_o` stay stable all 5 cycles; the request is accepted on the first ready cycle; no done pulse.
